phy_reg_free_list: RTL

- Allocator side of the physical-register lifecycle: owns the pool of free physical registers, hands them out to the Issue Controller, and takes back registers that the retire logic reclaims.
- Grant outputs drive the register file's allocate port directly: alloc_gnt goes to alloc_wen and alloc_pr goes to alloc_pr.
- Physical registers 0..NUM_ARCH_REGS-1 are the permanent architectural initial mapping. They are never in the list and are never freed.

---
 rtl/phy_reg_free_list.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/phy_reg_free_list.sv
// Free list of renamable physical registers: a circular FIFO that hands registers
// to the allocate ports in ascending port order and takes back retired registers.
module phy_reg_free_list #(
    parameter int NUM_PHY_REGS  = 64,
    parameter int NUM_SICS      = 2,
    parameter int NUM_ARCH_REGS = 32,
    localparam int PW    = $clog2(NUM_PHY_REGS),
    localparam int DEPTH = NUM_PHY_REGS - NUM_ARCH_REGS,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int HW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SICS-1:0]          alloc_req,
    output logic [NUM_SICS-1:0]          alloc_gnt,
    output logic [NUM_SICS-1:0][PW-1:0]  alloc_pr,
    input  logic [NUM_SICS-1:0]          free_wen,
    input  logic [NUM_SICS-1:0][PW-1:0]  free_pr,
    output logic [CW-1:0]                free_count,
    output logic                         empty
);

    logic [PW-1:0]           fifo_r [DEPTH];
    logic [HW-1:0]           head_r;
    logic [HW-1:0]           tail_r;
    logic [CW-1:0]           count_r;
    logic [NUM_PHY_REGS-1:0] in_list_r;

    logic [CW-1:0]                gnt_cnt_s;
    logic [CW-1:0]                free_cnt_s;
    logic [NUM_SICS-1:0][HW-1:0]  wr_idx_s;
    logic [CW:0]                  count_next_s;

    // Pointer advance modulo DEPTH; the offset never exceeds NUM_SICS.
    function automatic logic [HW-1:0] ptr_add(input logic [HW-1:0] base, input logic [CW-1:0] off);
        logic [CW:0] sum;
        sum = (CW+1)'(base) + (CW+1)'(off);
        if (sum >= (CW+1)'(DEPTH)) begin
            sum = sum - (CW+1)'(DEPTH);
        end else begin
            sum = sum;
        end
        return sum[HW-1:0];
    endfunction

    // Rank-ordered grants from the registered head; nothing freed this cycle is visible.
    always_comb begin
        gnt_cnt_s = {CW{1'b0}};
        alloc_gnt = {NUM_SICS{1'b0}};
        alloc_pr  = '0;
        for (int s = 0; s < NUM_SICS; s++) begin
            if (rst_n && alloc_req[s] && (gnt_cnt_s < count_r)) begin
                alloc_gnt[s] = 1'b1;
                alloc_pr[s]  = fifo_r[ptr_add(head_r, gnt_cnt_s)];
                gnt_cnt_s    = gnt_cnt_s + CW'(1);
            end else begin
                alloc_pr[s]  = {PW{1'b0}};
            end
        end
    end

    // Rank-ordered write slots for returned registers and the resulting occupancy.
    always_comb begin
        free_cnt_s = {CW{1'b0}};
        wr_idx_s   = '0;
        for (int s = 0; s < NUM_SICS; s++) begin
            wr_idx_s[s] = ptr_add(tail_r, free_cnt_s);
            if (free_wen[s]) begin
                free_cnt_s = free_cnt_s + CW'(1);
            end else begin
                free_cnt_s = free_cnt_s;
            end
        end
        count_next_s = (CW+1)'(count_r) - (CW+1)'(gnt_cnt_s) + (CW+1)'(free_cnt_s);
    end

    // List state: reset restores the initial pool, otherwise consume grants and append frees.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= PW'(NUM_ARCH_REGS + i);
            end
            for (int p = 0; p < NUM_PHY_REGS; p++) begin
                in_list_r[p] <= (p >= NUM_ARCH_REGS) ? 1'b1 : 1'b0;
            end
            head_r  <= {HW{1'b0}};
            tail_r  <= {HW{1'b0}};
            count_r <= CW'(DEPTH);
        end else begin
            head_r  <= ptr_add(head_r, gnt_cnt_s);
            tail_r  <= ptr_add(tail_r, free_cnt_s);
            count_r <= count_next_s[CW-1:0];
            for (int s = 0; s < NUM_SICS; s++) begin
                if (alloc_gnt[s]) begin
                    in_list_r[alloc_pr[s]] <= 1'b0;
                end
            end
            for (int s = 0; s < NUM_SICS; s++) begin
                if (free_wen[s]) begin
                    fifo_r[wr_idx_s[s]]   <= free_pr[s];
                    in_list_r[free_pr[s]] <= 1'b1;
                end
            end
        end
    end

    assign free_count = count_r;
    assign empty      = (count_r == {CW{1'b0}});

    phy_reg_free_list_chk #(
        .NUM_PHY_REGS  (NUM_PHY_REGS),
        .NUM_SICS      (NUM_SICS),
        .NUM_ARCH_REGS (NUM_ARCH_REGS)
    ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .free_wen     (free_wen),
        .free_pr      (free_pr),
        .in_list      (in_list_r),
        .count_next   (count_next_s)
    );

endmodule

// Debug checker for the free list: catches illegal frees, double frees and overflow.
module phy_reg_free_list_chk #(
    parameter int NUM_PHY_REGS  = 64,
    parameter int NUM_SICS      = 2,
    parameter int NUM_ARCH_REGS = 32,
    localparam int PW    = $clog2(NUM_PHY_REGS),
    localparam int DEPTH = NUM_PHY_REGS - NUM_ARCH_REGS,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SICS-1:0]          free_wen,
    input  logic [NUM_SICS-1:0][PW-1:0]  free_pr,
    input  logic [NUM_PHY_REGS-1:0]      in_list,
    input  logic [CW:0]                  count_next
);

    // Two ports returning the same register in one cycle count as a double free.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int s = 0; s < NUM_SICS; s++) begin
                if (free_wen[s] && (free_pr[s] < PW'(NUM_ARCH_REGS))) begin
                    $fatal(1, "illegal free of pr %0d", free_pr[s]);
                end
                if (free_wen[s] && in_list[free_pr[s]]) begin
                    $fatal(1, "double free of pr %0d", free_pr[s]);
                end
                for (int t = s + 1; t < NUM_SICS; t++) begin
                    if (free_wen[s] && free_wen[t] && (free_pr[s] == free_pr[t])) begin
                        $fatal(1, "double free of pr %0d", free_pr[s]);
                    end
                end
            end
            if (count_next > (CW+1)'(DEPTH)) begin
                $fatal(1, "overflow");
            end
        end
    end

endmodule
